// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, default sizes and helpers for the multi-port register file
package regfile_pkg;

    // Clear engine state: sweeping zeros into the array, or contents usable.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 64;
    localparam int RF_DEPTH  = 32;
    localparam int RF_NUM_RD = 2;

    // Address width for a given depth; a single-entry file still carries one address bit.
    function automatic int rf_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port: not-ready/zero/range/bypass/array mux
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = rf_addr_w(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] ra,
    input  logic              wr_legal,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] rd
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic in_range;
    logic is_zero;
    logic fwd_hit;

    assign in_range = ({1'b0, ra} < DEPTH_X);
    assign is_zero  = (ZERO_REG != 0) && (ra == '0);
    // wr_legal already folds in ready, the zero entry and the range check on wa.
    assign fwd_hit  = (BYPASS != 0) && wr_legal && (wa == ra);

    // Priority select: not ready, hardwired zero, out of range, forwarded write, array.
    always_comb begin
        rd = mem_data;
        if (!ready) begin
            rd = '0;
        end else if (is_zero) begin
            rd = '0;
        end else if (!in_range) begin
            rd = '0;
        end else if (fwd_hit) begin
            rd = wd;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with clear engine and optional bypass
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = rf_addr_w(DEPTH),
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear_req,
    output logic                          ready,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             wa,
    input  logic [DATA_W-1:0]             wd,
    input  logic [NUM_RD-1:0][ADDR_W-1:0] ra,
    output logic [NUM_RD-1:0][DATA_W-1:0] rd
);

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         state;
    rf_state_e         state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic              wr_legal;

    // Storage has no reset; the sweep below is what makes it all-zero.
    logic [DATA_W-1:0] mem [DEPTH];

    assign ready = (state == RF_READY);

    // A write lands only when ready, in range, and not aimed at the hardwired zero entry.
    assign wr_legal = ready && we
                    && ({1'b0, wa} < DEPTH_X)
                    && !((ZERO_REG != 0) && (wa == '0));

    // Clear engine next state: finish after the last entry, restart on request when ready.
    always_comb begin
        state_nxt = state;
        case (state)
            RF_CLEAR: if (clr_ptr == LAST_IDX) state_nxt = RF_READY;
            RF_READY: if (clear_req) state_nxt = RF_CLEAR;
            default:  state_nxt = RF_CLEAR;
        endcase
    end

    // State register and sweep pointer; reset at any time restarts the sweep at entry 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RF_CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == RF_CLEAR) begin
                clr_ptr <= (clr_ptr == LAST_IDX) ? '0 : clr_ptr + 1'b1;
            end else begin
                clr_ptr <= '0;
            end
        end
    end

    // Array write port: the sweep owns it while clearing, otherwise legal writes.
    always_ff @(posedge clk) begin
        if (state == RF_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_legal) begin
            mem[wa] <= wd;
        end
    end

    // Read ports; the array value is only used by the port when ra is in range.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [DATA_W-1:0] mem_data;

            assign mem_data = mem[ra[gi]];

            regfile_rd_port #(
                .DATA_W   (DATA_W),
                .DEPTH    (DEPTH),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd_port (
                .ready    (ready),
                .ra       (ra[gi]),
                .wr_legal (wr_legal),
                .wa       (wa),
                .wd       (wd),
                .mem_data (mem_data),
                .rd       (rd[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp (bypass, no-bypass, depth-20 builds)
module tb_regfile_mp;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clear_req;
    logic                 we;
    logic [4:0]           wa;
    logic [63:0]          wd;
    logic [1:0][4:0]      ra;

    logic                 ready_a, ready_b, ready_c;
    logic [1:0][63:0]     rd_a, rd_b, rd_c;

    int total = 0;
    int bad   = 0;

    // Expected-value scoreboard: tag, observed-signal selector, value.
    string       tag_q[$];
    int          sel_q[$];
    logic [63:0] exp_q[$];

    // Independent models: a/b share depth 32, c has depth 20.
    logic [63:0] ma [32];
    logic [63:0] mc [20];

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_a),
        .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a));

    regfile_mp #(.DATA_W(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_b),
        .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b));

    regfile_mp #(.DATA_W(64), .DEPTH(20), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_c (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_c),
        .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_c));

    function automatic logic [63:0] observe(input int s);
        case (s)
            0: return {63'b0, ready_a};
            1: return rd_a[0];
            2: return rd_a[1];
            3: return {63'b0, ready_b};
            4: return rd_b[0];
            5: return rd_b[1];
            6: return {63'b0, ready_c};
            7: return rd_c[0];
            default: return rd_c[1];
        endcase
    endfunction

    task automatic push_exp(input string t, input int s, input logic [63:0] v);
        tag_q.push_back(t);
        sel_q.push_back(s);
        exp_q.push_back(v);
    endtask

    task automatic drain();
        while (sel_q.size() > 0) begin
            string       t;
            int          s;
            logic [63:0] e;
            logic [63:0] o;
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            o = observe(s);
            total++;
            assert (o === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", t, o, e);
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
        drain();
    endtask

    task automatic model_write(input logic [4:0] a, input logic [63:0] d);
        if (a != 5'd0) ma[a] = d;
        if (a != 5'd0 && a < 5'd20) mc[a] = d;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 32; k++) ma[k] = '0;
        for (int k = 0; k < 20; k++) mc[k] = '0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear_req = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
        model_clear();
        repeat (2) tick();

        // Reset state: not ready, reads forced to zero.
        ra[0] = 5'd3; ra[1] = 5'd31;
        push_exp("rst_ready_a", 0, 64'd0);
        push_exp("rst_rd0_a",   1, 64'd0);
        push_exp("rst_rd1_a",   2, 64'd0);
        push_exp("rst_ready_c", 6, 64'd0);
        settle();

        // Initial sweep: a/b ready after 32 edges, c after 20.
        reset = 1'b0;
        for (int c = 0; c <= 32; c++) begin
            if (c > 0) tick();
            push_exp($sformatf("init_ready_a_c%0d", c), 0, 64'(c >= 32));
            push_exp($sformatf("init_ready_b_c%0d", c), 3, 64'(c >= 32));
            push_exp($sformatf("init_ready_c_c%0d", c), 6, 64'(c >= 20));
            push_exp($sformatf("init_rd0_a_c%0d", c),   1, 64'd0);
            settle();
        end
        for (int i = 0; i < 32; i++) begin
            ra[0] = 5'(i); ra[1] = 5'(31 - i);
            push_exp($sformatf("init_zero_rd0_a_%0d", i), 1, 64'd0);
            push_exp($sformatf("init_zero_rd1_b_%0d", i), 5, 64'd0);
            settle();
        end

        // Write 5 with same-cycle read: bypass builds forward, no-bypass build shows old value.
        we = 1'b1; wa = 5'd5; wd = 64'hDEAD_BEEF; ra[0] = 5'd5; ra[1] = 5'd6;
        push_exp("byp_rd0_a",   1, 64'hDEAD_BEEF);
        push_exp("byp_rd1_a",   2, 64'd0);
        push_exp("nobyp_rd0_b", 4, 64'd0);
        push_exp("byp_rd0_c",   7, 64'hDEAD_BEEF);
        settle();
        model_write(5'd5, 64'hDEAD_BEEF);
        tick(); we = 1'b0;
        push_exp("post_rd0_a", 1, ma[5]);
        push_exp("post_rd0_b", 4, ma[5]);
        push_exp("post_rd0_c", 7, mc[5]);
        settle();

        // Writes to entry 0 are dropped; it reads zero even while being written.
        we = 1'b1; wa = 5'd0; wd = '1; ra[0] = 5'd0; ra[1] = 5'd0;
        push_exp("z0_wr_rd0_a", 1, 64'd0);
        push_exp("z0_wr_rd1_a", 2, 64'd0);
        push_exp("z0_wr_rd0_c", 7, 64'd0);
        settle();
        tick(); we = 1'b0;
        push_exp("z0_after_rd0_a", 1, 64'd0);
        push_exp("z0_after_rd0_b", 4, 64'd0);
        settle();

        // Both ports on entry 7.
        we = 1'b1; wa = 5'd7; wd = 64'd7; ra[0] = 5'd7; ra[1] = 5'd7;
        push_exp("dual_wr_rd0_a", 1, 64'd7);
        push_exp("dual_wr_rd1_a", 2, 64'd7);
        push_exp("dual_wr_rd0_b", 4, 64'd0);
        push_exp("dual_wr_rd1_b", 5, 64'd0);
        settle();
        model_write(5'd7, 64'd7);
        tick(); we = 1'b0;
        push_exp("dual_rd0_a", 1, 64'd7);
        push_exp("dual_rd1_a", 2, 64'd7);
        push_exp("dual_rd0_b", 4, 64'd7);
        push_exp("dual_rd1_b", 5, 64'd7);
        push_exp("dual_rd0_c", 7, 64'd7);
        push_exp("dual_rd1_c", 8, 64'd7);
        settle();

        // Depth-20 build: out-of-range write dropped and not forwarded; entry 19 usable.
        we = 1'b1; wa = 5'd25; wd = 64'h1234; ra[0] = 5'd25; ra[1] = 5'd19;
        push_exp("d20_wr25_rd0_c", 7, 64'd0);
        push_exp("d20_wr25_rd1_c", 8, 64'd0);
        push_exp("d32_wr25_rd0_a", 1, 64'h1234);
        settle();
        model_write(5'd25, 64'h1234);
        tick();
        wa = 5'd19; wd = 64'h19AB;
        push_exp("d20_rd25_c",    7, 64'd0);
        push_exp("d20_byp19_c",   8, 64'h19AB);
        push_exp("d32_rd25_a",    1, ma[25]);
        settle();
        model_write(5'd19, 64'h19AB);
        tick(); we = 1'b0;
        ra[0] = 5'd19; ra[1] = 5'd20;
        push_exp("d20_rd19_c", 7, mc[19]);
        push_exp("d20_rd20_c", 8, 64'd0);
        push_exp("d32_rd20_a", 2, ma[20]);
        settle();

        // Fill 1..31 with their index, then read everything back.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 64'(i);
            model_write(5'(i), 64'(i));
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra[0] = 5'(i); ra[1] = 5'(31 - i);
            push_exp($sformatf("fill_rd0_a_%0d", i), 1, ma[i]);
            push_exp($sformatf("fill_rd1_a_%0d", i), 2, ma[31 - i]);
            push_exp($sformatf("fill_rd0_b_%0d", i), 4, ma[i]);
            push_exp($sformatf("fill_rd0_c_%0d", i), 7, (i < 20) ? mc[i] : 64'd0);
            settle();
        end

        // Clear request: ready drops next cycle, writes and a second request ignored in sweep.
        ra[0] = 5'd31; ra[1] = 5'd2;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        push_exp("clr_ready_a_c0", 0, 64'd0);
        push_exp("clr_ready_c_c0", 6, 64'd0);
        push_exp("clr_rd0_a_c0",   1, 64'd0);
        settle();
        for (int c = 1; c <= 32; c++) begin
            tick();
            we = (c >= 10 && c <= 15);
            wa = 5'd2; wd = 64'hFF;
            clear_req = (c == 12);
            push_exp($sformatf("clr_ready_a_c%0d", c), 0, 64'(c >= 32));
            push_exp($sformatf("clr_ready_c_c%0d", c), 6, 64'(c >= 20));
            push_exp($sformatf("clr_rd0_a_c%0d", c),   1, 64'd0);
            settle();
        end
        we = 1'b0; clear_req = 1'b0;
        model_clear();
        for (int i = 0; i < 32; i++) begin
            ra[0] = 5'(i); ra[1] = 5'(i);
            push_exp($sformatf("clr_done_rd0_a_%0d", i), 1, ma[i]);
            push_exp($sformatf("clr_done_rd1_b_%0d", i), 5, ma[i]);
            push_exp($sformatf("clr_done_rd0_c_%0d", i), 7, (i < 20) ? mc[i] : 64'd0);
            settle();
        end

        // Reset in the middle of a sweep restarts the full sweep.
        we = 1'b1; wa = 5'd9; wd = 64'h99;
        model_write(5'd9, 64'h99);
        tick(); we = 1'b0;
        ra[0] = 5'd9;
        push_exp("pre_rst_rd0_a", 1, ma[9]);
        settle();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        push_exp("midrst_ready_a", 0, 64'd0);
        push_exp("midrst_rd0_a",   1, 64'd0);
        settle();
        repeat (2) tick();
        reset = 1'b0;
        model_clear();
        for (int c = 1; c <= 32; c++) begin
            tick();
            push_exp($sformatf("rst_sweep_ready_a_c%0d", c), 0, 64'(c >= 32));
            push_exp($sformatf("rst_sweep_ready_c_c%0d", c), 6, 64'(c >= 20));
            settle();
        end
        push_exp("rst_sweep_rd9_a", 1, ma[9]);
        settle();

        // Writes work again after the restarted sweep.
        we = 1'b1; wa = 5'd3; wd = 64'h33; ra[0] = 5'd3;
        model_write(5'd3, 64'h33);
        tick(); we = 1'b0;
        push_exp("final_rd0_a", 1, ma[3]);
        push_exp("final_rd0_b", 4, ma[3]);
        push_exp("final_rd0_c", 7, mc[3]);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
